// File: rtl/pkt_rx_reader.sv
// -----------------------------------------------------------------------------
// pkt_rx_reader
//
// Host-side consumer of the MAC packet receive interface. It waits for the MAC
// to report a complete frame (pkt_rx_avail). It then issues read enables
// (pkt_rx_ren) and catches the returned words one cycle later into a small
// first-word-fall-through FIFO. The words leave the FIFO as a valid/ready
// stream. SOP/EOP framing is checked on the way in. Optional statistics
// counters track frames, bytes and errored frames.
//
// Build option:
//   PKT_RX_STATS_EN  - when defined, frm_cnt/byte_cnt/err_cnt count traffic;
//                      when undefined the counter logic is absent and the
//                      three ports read as zero.
//
// Parameters:
//   FIFO_DEPTH  output buffer depth in 64-bit words (power of 2, >= 2)
//   CNT_W       width of each statistics counter
//
// Ports:
//   clk_156m25      in   single clock for all logic
//   reset_156m25_n  in   asynchronous active-low reset
//   pkt_rx_avail    in   MAC holds at least one complete frame
//   pkt_rx_ren      out  read enable to MAC; data returns one cycle later
//   pkt_rx_val      in   MAC word valid this cycle
//   pkt_rx_data     in   64-bit frame word
//   pkt_rx_sop/eop  in   frame delimiters
//   pkt_rx_mod      in   valid bytes in EOP word (0 = all 8)
//   pkt_rx_err      in   MAC frame error, meaningful on the EOP word
//   out_val         out  stream word valid
//   out_ready       in   stream sink accepts (transfer = out_val & out_ready)
//   out_data        out  stream word
//   out_sop/eop/mod out  copied from the MAC
//   out_err         out  MAC error or framing error, flagged on the EOP word
//   frm_cnt         out  frames whose EOP word entered the FIFO
//   byte_cnt        out  payload bytes written to the FIFO
//   err_cnt         out  frames delivered with out_err set
// -----------------------------------------------------------------------------
module pkt_rx_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic             pkt_rx_val,
  input  logic [63:0]      pkt_rx_data,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  output logic             out_val,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [2:0]       out_mod,
  output logic             out_err,
  output logic [CNT_W-1:0] frm_cnt,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = AW + 1;
  // Each FIFO entry holds {data, sop, eop, mod, err}.
  localparam int EW = 64 + 1 + 1 + 3 + 1;

  localparam logic [OW:0] DEPTH_C = (OW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          ren_q;
  logic [OW-1:0] occ_q, occ_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          in_frame_q, in_frame_d;
  logic          ferr_q, ferr_d;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] head;

  logic          wr_en;
  logic          rd_en;
  logic          eop_seen;
  logic [OW:0]   credit_used;
  logic          frm_bad;
  logic          wr_err;

  // A returned word is accepted only when a read was issued the cycle before;
  // stray valids from the MAC are dropped.
  assign wr_en    = pkt_rx_val & ren_q;
  assign rd_en    = out_val & out_ready;
  assign eop_seen = pkt_rx_val & pkt_rx_eop;

  // Credit covers both stored words and the one in flight from the MAC. A slot
  // freed by a read this cycle becomes usable on the next cycle. Every word
  // that arrives therefore has a free slot waiting for it.
  assign credit_used = {1'b0, occ_q} + {{OW{1'b0}}, ren_q};

  // The read enable is cut combinationally on the EOP word, so the MAC is
  // never asked for a word past the end of the frame.
  assign pkt_rx_ren = (state_q == ST_RD) & (credit_used < DEPTH_C) & ~eop_seen;

  // ---------------------------------------------------------------------------
  // Read-side FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pkt_rx_avail) state_d = ST_RD;
      // Avail may drop mid-frame; reading continues until the EOP word.
      ST_RD:   if (eop_seen) state_d = ST_GAP;
      // One idle cycle gives the MAC time to update pkt_rx_avail.
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Framing check
  // ---------------------------------------------------------------------------
  // A word is out of place if it lacks SOP while outside a frame, or carries
  // SOP while inside one. The error is remembered until the EOP word and is
  // reported there, together with any error the MAC flags.
  assign frm_bad = in_frame_q ? pkt_rx_sop : ~pkt_rx_sop;
  assign wr_err  = pkt_rx_eop & (pkt_rx_err | ferr_q | frm_bad);

  always_comb begin
    in_frame_d = in_frame_q;
    ferr_d     = ferr_q;
    if (wr_en) begin
      if (pkt_rx_eop) begin
        in_frame_d = 1'b0;
        ferr_d     = 1'b0;
      end else begin
        in_frame_d = 1'b1;
        ferr_d     = ferr_q | frm_bad;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (wr_en) wptr_d = wptr_q + AW'(1);
    if (rd_en) rptr_d = rptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state_q    <= ST_IDLE;
      ren_q      <= 1'b0;
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      in_frame_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ren_q      <= pkt_rx_ren;
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      in_frame_q <= in_frame_d;
      ferr_q     <= ferr_d;
    end
  end

  // Storage has no reset. An entry is only visible once occupancy covers it.
  always_ff @(posedge clk_156m25) begin
    if (wr_en) mem_q[wptr_q] <= {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod, wr_err};
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through output
  // ---------------------------------------------------------------------------
  // The head entry is shown directly. While the FIFO is empty the outputs are
  // forced to zero, so reset and idle both present a clean bus. The head entry
  // cannot change until it is read, so the outputs hold under backpressure.
  assign head    = mem_q[rptr_q];
  assign out_val = (occ_q != '0);

  always_comb begin
    out_data = '0;
    out_sop  = 1'b0;
    out_eop  = 1'b0;
    out_mod  = '0;
    out_err  = 1'b0;
    if (out_val) begin
      out_data = head[EW-1 -: 64];
      out_sop  = head[5];
      out_eop  = head[4];
      out_mod  = head[3:1];
      out_err  = head[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef PKT_RX_STATS_EN
  logic [CNT_W-1:0] frm_cnt_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [3:0]       byte_inc;

  // A mod value of zero on the EOP word means the whole word is valid.
  always_comb begin
    byte_inc = 4'd8;
    if (pkt_rx_eop && (pkt_rx_mod != 3'd0)) byte_inc = {1'b0, pkt_rx_mod};
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      frm_cnt_q  <= '0;
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (wr_en) begin
      byte_cnt_q <= byte_cnt_q + CNT_W'(byte_inc);
      if (pkt_rx_eop) begin
        frm_cnt_q <= frm_cnt_q + CNT_W'(1);
        if (wr_err) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

  assign frm_cnt  = frm_cnt_q;
  assign byte_cnt = byte_cnt_q;
  assign err_cnt  = err_cnt_q;
`else
  assign frm_cnt  = '0;
  assign byte_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_pkt_rx_reader.sv
module tb_pkt_rx_reader;

  localparam int DEPTH = 4;
  localparam int CW    = 32;
`ifdef PKT_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pkt_rx_avail;
  logic          pkt_rx_ren;
  logic          pkt_rx_val = 1'b0;
  logic [63:0]   pkt_rx_data = '0;
  logic          pkt_rx_sop = 1'b0;
  logic          pkt_rx_eop = 1'b0;
  logic [2:0]    pkt_rx_mod = '0;
  logic          pkt_rx_err = 1'b0;
  logic          out_val;
  logic          out_ready = 1'b1;
  logic [63:0]   out_data;
  logic          out_sop;
  logic          out_eop;
  logic [2:0]    out_mod;
  logic          out_err;
  logic [CW-1:0] frm_cnt;
  logic [CW-1:0] byte_cnt;
  logic [CW-1:0] err_cnt;

  word_t mac_q[$];
  word_t exp_q[$];
  int    mac_frames = 0;
  int    mac_sent   = 0;
  int    n_out      = 0;
  int    n_checks   = 0;
  int    n_errors   = 0;
  int    seq        = 0;
  logic  ren_seen   = 1'b0;

  assign pkt_rx_avail = (mac_frames != 0);

  always #5 clk = ~clk;

  pkt_rx_reader #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .pkt_rx_avail   (pkt_rx_avail),
    .pkt_rx_ren     (pkt_rx_ren),
    .pkt_rx_val     (pkt_rx_val),
    .pkt_rx_data    (pkt_rx_data),
    .pkt_rx_sop     (pkt_rx_sop),
    .pkt_rx_eop     (pkt_rx_eop),
    .pkt_rx_mod     (pkt_rx_mod),
    .pkt_rx_err     (pkt_rx_err),
    .out_val        (out_val),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_mod        (out_mod),
    .out_err        (out_err),
    .frm_cnt        (frm_cnt),
    .byte_cnt       (byte_cnt),
    .err_cnt        (err_cnt)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] cexp(input int v);
    return STATS ? 72'(v) : 72'd0;
  endfunction

  // MAC model: a read enable seen in one cycle returns the next queued word
  // in the following cycle.
  always @(negedge clk) ren_seen = pkt_rx_ren;

  always @(posedge clk) begin
    word_t w;
    #1;
    if (rst_n && ren_seen && mac_q.size() != 0) begin
      w = mac_q.pop_front();
      pkt_rx_val  = 1'b1;
      pkt_rx_data = w.d;
      pkt_rx_sop  = w.sop;
      pkt_rx_eop  = w.eop;
      pkt_rx_mod  = w.mod;
      pkt_rx_err  = w.err;
      mac_sent++;
      if (w.eop) mac_frames--;
    end else begin
      pkt_rx_val  = 1'b0;
      pkt_rx_data = '0;
      pkt_rx_sop  = 1'b0;
      pkt_rx_eop  = 1'b0;
      pkt_rx_mod  = '0;
      pkt_rx_err  = 1'b0;
    end
  end

  // Stream monitor: scoreboard, hold-under-backpressure and EOP read-kill.
  word_t obs_w, hold_w;
  logic  hold_v = 1'b0;
  always @(negedge clk) begin
    word_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      obs_w = {out_data, out_sop, out_eop, out_mod, out_err};
      if (hold_v) check("hold_stable", 72'({out_val, obs_w}), 72'({1'b1, hold_w}));
      if (out_val && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_word", 72'(exp_q.size()), 72'd1);
        end else begin
          e = exp_q.pop_front();
          check("stream_word", 72'(obs_w), 72'(e));
        end
        n_out++;
      end
      if (pkt_rx_val && pkt_rx_eop) check("ren_kill_on_eop", 72'(pkt_rx_ren), 72'd0);
      hold_v = out_val & ~out_ready;
      hold_w = obs_w;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sop, input logic eop, input logic [2:0] mod,
                      input logic mac_err, input logic exp_err);
    word_t w;
    logic [31:0] s;
    s     = 32'(seq);
    seq++;
    w.d   = {~s ^ 32'h5A5A_0000, s};
    w.sop = sop;
    w.eop = eop;
    w.mod = mod;
    w.err = mac_err;
    mac_q.push_back(w);
    w.err = eop & exp_err;
    exp_q.push_back(w);
    if (eop) mac_frames++;
  endtask

  task automatic send_frame(input int n, input logic [2:0] mod, input logic mac_err,
                            input logic exp_err);
    for (int i = 0; i < n; i++)
      push(i == 0, i == n - 1, (i == n - 1) ? mod : 3'd0, (i == n - 1) ? mac_err : 1'b0, exp_err);
  endtask

  task automatic drain(input string tag, input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || mac_q.size() != 0) && i < budget) begin
      cyc(1);
      i++;
    end
    check(tag, 72'(exp_q.size() + mac_q.size()), 72'd0);
    cyc(2);
  endtask

  task automatic check_counters(input string tag, input int f, input int b, input int e);
    check({tag, "_frm"},  72'(frm_cnt),  cexp(f));
    check({tag, "_byte"}, 72'(byte_cnt), cexp(b));
    check({tag, "_err"},  72'(err_cnt),  cexp(e));
  endtask

  initial begin
    int  run;
    bit  found;
    int  base;

    // Reset state
    rst_n     = 1'b0;
    out_ready = 1'b1;
    cyc(3);
    check("rst_ren",     72'(pkt_rx_ren), 72'd0);
    check("rst_out_val", 72'(out_val),    72'd0);
    check("rst_out_bus", 72'({out_data, out_sop, out_eop, out_mod, out_err}), 72'd0);
    check("rst_frm",     72'(frm_cnt),    72'd0);
    check("rst_byte",    72'(byte_cnt),   72'd0);
    check("rst_err",     72'(err_cnt),    72'd0);
    rst_n = 1'b1;
    cyc(2);

    // 64-byte frame, sink always ready: 1-cycle latency, 1 word/cycle
    send_frame(8, 3'd0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pkt_rx_val) begin found = 1'b1; break; end
    end
    check("t1_mac_val_seen", 72'(found), 72'd1);
    check("t1_out_empty_before_write", 72'(out_val), 72'd0);
    @(negedge clk);
    check("t1_latency_sop", 72'({out_val, out_sop}), 72'b11);
    run = 0;
    repeat (8) begin
      if (out_val && out_ready) run++;
      @(negedge clk);
    end
    check("t1_throughput", 72'(run), 72'd8);
    drain("t1_drain", 50);
    check_counters("t1", 1, 64, 0);

    // 61-byte frame then 16-byte frame: read kill on EOP, idle gap after
    send_frame(8, 3'd5, 1'b0, 1'b0);
    send_frame(2, 3'd0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pkt_rx_val && pkt_rx_eop) begin found = 1'b1; break; end
    end
    check("t2_eop_seen", 72'(found), 72'd1);
    @(negedge clk);
    check("t2_ren_gap", 72'(pkt_rx_ren), 72'd0);
    @(negedge clk);
    check("t2_ren_idle", 72'(pkt_rx_ren), 72'd0);
    @(negedge clk);
    check("t2_ren_resume", 72'(pkt_rx_ren), 72'd1);
    drain("t2_drain", 60);
    check_counters("t2", 3, 141, 0);

    // Backpressure for 20 cycles mid-frame
    base = n_out;
    send_frame(8, 3'd0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (n_out >= base + 2) begin found = 1'b1; break; end
    end
    check("t3_started", 72'(found), 72'd1);
    out_ready = 1'b0;
    cyc(20);
    check("t3_words_held", 72'(mac_sent - n_out), 72'(DEPTH));
    check("t3_ren_stopped", 72'(pkt_rx_ren), 72'd0);
    check("t3_out_val_held", 72'(out_val), 72'd1);
    out_ready = 1'b1;
    drain("t3_drain", 60);
    check_counters("t3", 4, 205, 0);

    // MAC-flagged error on EOP (3 words, mod=2)
    send_frame(3, 3'd2, 1'b1, 1'b1);
    drain("t4_drain", 40);
    check_counters("t4", 5, 223, 1);

    // Two SOPs before EOP
    push(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    push(1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    drain("t5_drain", 40);
    check_counters("t5", 6, 247, 2);

    // Frame starting without SOP
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    push(1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    drain("t6_drain", 40);
    check_counters("t6", 7, 263, 3);

    // Single-word frame, SOP and EOP together, mod=1
    push(1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    drain("t7_drain", 40);
    check_counters("t7", 8, 264, 3);

    // Reset asserted mid-frame with the FIFO full
    out_ready = 1'b0;
    send_frame(8, 3'd0, 1'b0, 1'b0);
    cyc(8);
    #1;
    rst_n = 1'b0;
    #1;
    check("t8_rst_ren",     72'(pkt_rx_ren), 72'd0);
    check("t8_rst_out_val", 72'(out_val),    72'd0);
    check("t8_rst_out_bus", 72'({out_data, out_sop, out_eop, out_mod, out_err}), 72'd0);
    check("t8_rst_frm",     72'(frm_cnt),    72'd0);
    check("t8_rst_byte",    72'(byte_cnt),   72'd0);
    check("t8_rst_err",     72'(err_cnt),    72'd0);
    mac_q.delete();
    exp_q.delete();
    mac_frames = 0;
    mac_sent   = 0;
    n_out      = 0;
    cyc(2);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    send_frame(2, 3'd0, 1'b0, 1'b0);
    drain("t8_drain", 40);
    check_counters("t8", 1, 16, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
